// File: rtl/mod_updown_counter_if.sv
// Handshake-free control/status bundle for mod_updown_counter.
// Latency: n/a (wires only). Backpressure: none, the counter accepts a command every cycle.
// master drives en/up/step/sat/ld/ld_val and observes count/tc/zero/ovf; slave is the counter side.
interface mod_updown_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              en;
    logic              up;
    logic [STEP_W-1:0] step;
    logic              sat;
    logic              ld;
    logic [WIDTH-1:0]  ld_val;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              zero;
    logic              ovf;

    modport master (
        output en, up, step, sat, ld, ld_val,
        input  count, tc, zero, ovf
    );

    modport slave (
        input  en, up, step, sat, ld, ld_val,
        output count, tc, zero, ovf
    );
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down counter, variable step, modulus MAX_COUNT+1, wrap or saturate, sync load, tc/zero/sticky ovf.
// Latency: one cycle from command to registered count/status. Backpressure: none, every edge is accepted.
// Ports: clk, rst (async active-low), bus (slave modport). Optional macro COUNTER_PRESCALE_EN adds an en divider.
module mod_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int STEP_W    = 4,
    parameter int PRESCALE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    mod_updown_counter_if.slave bus
);
    // Parameter legality is enforced at elaboration.
    if (MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH - 1) begin : g_bad_max
        $fatal(1, "mod_updown_counter: MAX_COUNT out of range 1..2**WIDTH-1");
    end
    if (2**STEP_W - 1 > MAX_COUNT + 1) begin : g_bad_step
        $fatal(1, "mod_updown_counter: largest step exceeds modulus");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_ps
        $fatal(1, "mod_updown_counter: PRESCALE out of range 1..65535");
    end

    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH:0]   MAX_W     = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0]   MODULUS_W = (WIDTH+1)'(MAX_COUNT + 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             eff_en;

`ifdef COUNTER_PRESCALE_EN
    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [15:0] ps_q, ps_d;
    logic        ps_tick;

    // Prescaler only advances on en cycles; load restarts the division phase.
    always_comb begin
        ps_d    = ps_q;
        ps_tick = 1'b0;
        if (bus.ld) begin
            ps_d = '0;
        end else if (bus.en) begin
            if (ps_q == PS_LAST) begin
                ps_d    = '0;
                ps_tick = 1'b1;
            end else begin
                ps_d = ps_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ps_q <= '0;
        else      ps_q <= ps_d;
    end

    assign eff_en = ps_tick;
`else
    assign eff_en = bus.en;
`endif

    // One guard bit so up-sums and down-borrows can be tested without overflow.
    logic [WIDTH:0] cnt_w, step_w, sum_w;
    assign cnt_w  = {1'b0, count_q};
    assign step_w = (WIDTH+1)'(bus.step);
    assign sum_w  = cnt_w + step_w;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (bus.ld) begin
            count_d = (bus.ld_val > MAX_V) ? MAX_V : bus.ld_val;
            ovf_d   = 1'b0;
        end else if (eff_en && (bus.step != '0)) begin
            if (bus.up) begin
                if (sum_w > MAX_W) begin
                    ovf_d = 1'b1;
                    if (bus.sat) begin
                        count_d = MAX_V;
                        // Already parked at the top: no fresh terminal event.
                        tc_d    = (count_q != MAX_V);
                    end else begin
                        count_d = WIDTH'(sum_w - MODULUS_W);
                        tc_d    = 1'b1;
                    end
                end else if (bus.sat && (sum_w == MAX_W)) begin
                    // step>0 here, so this is the first arrival at the top.
                    count_d = MAX_V;
                    tc_d    = 1'b1;
                end else begin
                    count_d = WIDTH'(sum_w);
                end
            end else begin
                if (step_w > cnt_w) begin
                    ovf_d = 1'b1;
                    if (bus.sat) begin
                        count_d = '0;
                        tc_d    = (count_q != '0);
                    end else begin
                        count_d = WIDTH'(cnt_w + MODULUS_W - step_w);
                        tc_d    = 1'b1;
                    end
                end else if (bus.sat && (step_w == cnt_w)) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = WIDTH'(cnt_w - step_w);
                end
            end
        end
        zero_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.zero  = zero_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three instances share one random/directed stimulus stream.
// Latency: expected results queued at stimulus time, popped one cycle later by the monitor.
// Backpressure: none; the counter produces a result every clock.
module tb_mod_updown_counter;
`ifdef COUNTER_PRESCALE_EN
    localparam int TB_PS = 4;
`else
    localparam int TB_PS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b0, sat = 1'b0, ld = 1'b0;
    logic [3:0] step = '0;
    logic [7:0] ld_val = '0;

    always #5 clk = ~clk;

    mod_updown_counter_if #(.WIDTH(4), .STEP_W(3)) if0 ();
    mod_updown_counter_if #(.WIDTH(8), .STEP_W(4)) if1 ();
    mod_updown_counter_if #(.WIDTH(8), .STEP_W(4)) if2 ();

    assign if0.en = en;  assign if0.up = up;  assign if0.sat = sat;  assign if0.ld = ld;
    assign if0.step = step[2:0];  assign if0.ld_val = ld_val[3:0];
    assign if1.en = en;  assign if1.up = up;  assign if1.sat = sat;  assign if1.ld = ld;
    assign if1.step = step;       assign if1.ld_val = ld_val;
    assign if2.en = en;  assign if2.up = up;  assign if2.sat = sat;  assign if2.ld = ld;
    assign if2.step = step;       assign if2.ld_val = ld_val;

    mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9),  .STEP_W(3), .PRESCALE(TB_PS)) u0 (.clk(clk), .rst(rst), .bus(if0));
    mod_updown_counter #(.WIDTH(8), .MAX_COUNT(255), .STEP_W(4), .PRESCALE(TB_PS)) u1 (.clk(clk), .rst(rst), .bus(if1));
    mod_updown_counter #(.WIDTH(8), .MAX_COUNT(99),  .STEP_W(4), .PRESCALE(TB_PS)) u2 (.clk(clk), .rst(rst), .bus(if2));

    // Observed word per instance: {ovf, zero, tc, count[7:0]}.
    logic [32:0] act_all;
    assign act_all = {if2.ovf, if2.zero, if2.tc, if2.count,
                      if1.ovf, if1.zero, if1.tc, if1.count,
                      if0.ovf, if0.zero, if0.tc, 4'b0000, if0.count};

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integer arithmetic on the counting rules.
    int maxc [3] = '{9, 255, 99};
    int smask[3] = '{7, 15, 15};
    int lmask[3] = '{15, 255, 255};
    int m_cnt[3], m_tc[3], m_ovf[3], m_ps[3];

    logic [32:0] sb[$];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_ps[i] = 0;
        end
    endtask

    task automatic model_edge(input int i, input bit e, input bit u, input bit s,
                              input bit l, input int st_in, input int lv_in,
                              output logic [10:0] obs);
        int st, lv, mx, nxt;
        bit tick;
        st = st_in & smask[i];
        lv = lv_in & lmask[i];
        mx = maxc[i];
        m_tc[i] = 0;
        if (l) begin
            m_cnt[i] = (lv > mx) ? mx : lv;
            m_ovf[i] = 0;
            m_ps[i]  = 0;
        end else if (e) begin
            tick = (m_ps[i] == TB_PS - 1);
            m_ps[i] = tick ? 0 : m_ps[i] + 1;
            if (tick && st != 0) begin
                if (u) nxt = m_cnt[i] + st;
                else   nxt = m_cnt[i] - st;
                if (nxt > mx || nxt < 0) m_ovf[i] = 1;
                if (!s) begin
                    if (nxt > mx)     begin nxt = nxt - (mx + 1); m_tc[i] = 1; end
                    else if (nxt < 0) begin nxt = nxt + (mx + 1); m_tc[i] = 1; end
                end else begin
                    if (nxt >= mx && u)       begin m_tc[i] = (m_cnt[i] != mx); nxt = mx; end
                    else if (nxt <= 0 && !u)  begin m_tc[i] = (m_cnt[i] != 0);  nxt = 0;  end
                end
                m_cnt[i] = nxt;
            end
        end
        obs = {m_ovf[i][0], (m_cnt[i] == 0), m_tc[i][0], 8'(m_cnt[i])};
    endtask

    // Call at a negedge: apply inputs, queue expected results, advance to next negedge.
    task automatic cyc(input bit e, input bit u, input bit s, input bit l,
                       input int st, input int lv);
        logic [10:0] o0, o1, o2;
        en = e; up = u; sat = s; ld = l; step = 4'(st); ld_val = 8'(lv);
        model_edge(0, e, u, s, l, st, lv, o0);
        model_edge(1, e, u, s, l, st, lv, o1);
        model_edge(2, e, u, s, l, st, lv, o2);
        sb.push_back({o2, o1, o0});
        @(negedge clk);
    endtask

    task automatic check_rst(input string name);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_all[i*11 +: 11] !== 11'h200) begin
                failures++;
                $display("FAIL %s inst=%0d got=%h exp=%h", name, i, act_all[i*11 +: 11], 11'h200);
            end
        end
    endtask

    // Monitor: one result per clock whenever an expectation is outstanding.
    initial begin
        logic [32:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (act_all[i*11 +: 11] !== e[i*11 +: 11]) begin
                        failures++;
                        $display("FAIL scoreboard inst=%0d t=%0t got{ovf,zero,tc,cnt}=%h exp=%h",
                                 i, $time, act_all[i*11 +: 11], e[i*11 +: 11]);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_rst("reset_init");
        rst = 1'b1;

        // Up wrap by 1: 1..9,0,1,2 on the modulus-10 instance.
        repeat (12) cyc(1, 1, 0, 0, 1, 0);
        // Down wrap: load 2, step 3 -> 9 with tc, then 6.
        cyc(0, 0, 0, 1, 0, 2);
        repeat (2) cyc(1, 0, 0, 0, 3, 0);
        // Saturate up from 250 by 4.
        cyc(0, 1, 1, 1, 0, 250);
        repeat (4) cyc(1, 1, 1, 0, 4, 0);
        // Load beats enable; clamps on the modulus-100 instance.
        cyc(1, 1, 0, 1, 1, 200);
        cyc(1, 1, 0, 0, 1, 0);
        // Saturate down to zero then hold.
        cyc(0, 0, 1, 1, 0, 5);
        repeat (4) cyc(1, 0, 1, 0, 2, 0);
        // Async reset between edges at count 37.
        cyc(0, 1, 0, 1, 0, 37);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_rst("reset_async");
        model_reset();
        en = 0; ld = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        // Enable held, then dropped for two cycles (exercises prescaler when built).
        repeat (12) cyc(1, 1, 0, 0, 1, 0);
        repeat (2)  cyc(0, 1, 0, 0, 1, 0);
        repeat (10) cyc(1, 1, 0, 0, 1, 0);
        // Randomised traffic.
        repeat (800) cyc($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
                         $urandom_range(0, 19) == 0, $urandom_range(0, 15), $urandom_range(0, 255));
        en = 0; ld = 0;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain outstanding=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
